// File: rtl/cacheline_adaptor_pkg.sv
// +-----------------------------------------------------------------------+
// | cacheline_adaptor_pkg: state type and default widths for the adaptor  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package cacheline_adaptor_pkg;

    localparam int C_LINE_WIDTH  = 256;
    localparam int C_BURST_WIDTH = 64;
    localparam int C_ADDR_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cacheline_burst_adaptor.sv
// +-----------------------------------------------------------------------+
// | cacheline_burst_adaptor: splits one cache-line request into bursts    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module cacheline_burst_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_WIDTH  = C_LINE_WIDTH,
    parameter int BURST_WIDTH = C_BURST_WIDTH,
    parameter int ADDR_WIDTH  = C_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    output logic                   busy_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int C_BEATS  = LINE_WIDTH / BURST_WIDTH;
    localparam int C_OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int C_CW     = $clog2(C_BEATS);
    // BEATS is a power of two, so the last beat index is all ones
    localparam logic [C_CW-1:0] C_LAST = {C_CW{1'b1}};

    state_t                  r_state;
    state_t                  w_next;
    logic [C_CW-1:0]         r_count;
    logic [LINE_WIDTH-1:0]   r_line;
    logic [LINE_WIDTH-1:0]   r_wbuf;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_read;
    logic                    r_write;
    logic                    r_resp;
    logic                    w_start;
    logic                    w_beat_ack;
    logic                    w_unused_offset;

    assign w_start         = (r_state == IDLE) && (read_i || write_i);
    assign w_beat_ack      = resp_i && ((r_state == READ) || (r_state == WRITE));
    assign w_unused_offset = ^address_i[C_OFFSET-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (read_i) begin
                    w_next = READ;
                end else if (write_i) begin
                    w_next = WRITE;
                end
            end
            READ: begin
                if (resp_i && (r_count == C_LAST)) begin
                    w_next = DONE;
                end
            end
            WRITE: begin
                if (resp_i && (r_count == C_LAST)) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        burst_o = '0;
        busy_o  = (r_state != IDLE);
        if (r_state == WRITE) begin
            burst_o = r_wbuf[r_count*BURST_WIDTH +: BURST_WIDTH];
        end
    end

    // Request strobes and the completion pulse follow the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
            r_line  <= '0;
            r_wbuf  <= '0;
        end else begin
            r_read  <= (w_next == READ);
            r_write <= (w_next == WRITE);
            r_resp  <= (w_next == DONE);
            if (w_start) begin
                r_addr  <= {address_i[ADDR_WIDTH-1:C_OFFSET], {C_OFFSET{1'b0}}};
                r_count <= '0;
                if (!read_i) begin
                    r_wbuf <= line_i;
                end
            end
            if (w_beat_ack) begin
                r_count <= r_count + 1'b1;
                if (r_state == READ) begin
                    r_line[r_count*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                end
            end
        end
    end

    assign line_o    = r_line;
    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;

endmodule

`default_nettype wire

// File: tb/tb_cacheline_burst_adaptor.sv
// +-----------------------------------------------------------------------+
// | tb_cacheline_burst_adaptor: randomized self-checking bench, 3 widths  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] tb_line = '0;
    logic [31:0]  tb_addr = '0;
    logic [63:0]  burst_in = '0;
    logic         resp_in = 1'b0;
    logic         req_rd = 1'b0;
    logic         req_wr = 1'b0;
    logic [1:0]   sel = 2'd0;

    logic [255:0] line_o0;
    logic [127:0] line_o1;
    logic [511:0] line_o2;
    logic [63:0]  burst_o0, burst_o1, burst_o2;
    logic [31:0]  addr_o0, addr_o1, addr_o2;
    logic         read_o0, read_o1, read_o2;
    logic         write_o0, write_o1, write_o2;
    logic         resp_o0, resp_o1, resp_o2;
    logic         busy_o0, busy_o1, busy_o2;

    logic [511:0] obs_line;
    logic [63:0]  obs_burst;
    logic [31:0]  obs_addr;
    logic         obs_read, obs_write, obs_resp, obs_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cacheline_burst_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) u_dut0 (
        .clk(clk), .reset(reset), .line_i(tb_line[255:0]), .line_o(line_o0),
        .address_i(tb_addr), .read_i(req_rd && sel == 2'd0), .write_i(req_wr && sel == 2'd0),
        .resp_o(resp_o0), .busy_o(busy_o0), .burst_i(burst_in), .burst_o(burst_o0),
        .address_o(addr_o0), .read_o(read_o0), .write_o(write_o0), .resp_i(resp_in && sel == 2'd0)
    );

    cacheline_burst_adaptor #(.LINE_WIDTH(128), .BURST_WIDTH(64), .ADDR_WIDTH(32)) u_dut1 (
        .clk(clk), .reset(reset), .line_i(tb_line[127:0]), .line_o(line_o1),
        .address_i(tb_addr), .read_i(req_rd && sel == 2'd1), .write_i(req_wr && sel == 2'd1),
        .resp_o(resp_o1), .busy_o(busy_o1), .burst_i(burst_in), .burst_o(burst_o1),
        .address_o(addr_o1), .read_o(read_o1), .write_o(write_o1), .resp_i(resp_in && sel == 2'd1)
    );

    cacheline_burst_adaptor #(.LINE_WIDTH(512), .BURST_WIDTH(64), .ADDR_WIDTH(32)) u_dut2 (
        .clk(clk), .reset(reset), .line_i(tb_line), .line_o(line_o2),
        .address_i(tb_addr), .read_i(req_rd && sel == 2'd2), .write_i(req_wr && sel == 2'd2),
        .resp_o(resp_o2), .busy_o(busy_o2), .burst_i(burst_in), .burst_o(burst_o2),
        .address_o(addr_o2), .read_o(read_o2), .write_o(write_o2), .resp_i(resp_in && sel == 2'd2)
    );

    always_comb begin
        case (sel)
            2'd1: begin
                obs_line = {384'b0, line_o1}; obs_burst = burst_o1; obs_addr = addr_o1;
                obs_read = read_o1; obs_write = write_o1; obs_resp = resp_o1; obs_busy = busy_o1;
            end
            2'd2: begin
                obs_line = line_o2; obs_burst = burst_o2; obs_addr = addr_o2;
                obs_read = read_o2; obs_write = write_o2; obs_resp = resp_o2; obs_busy = busy_o2;
            end
            default: begin
                obs_line = {256'b0, line_o0}; obs_burst = burst_o0; obs_addr = addr_o0;
                obs_read = read_o0; obs_write = write_o0; obs_resp = resp_o0; obs_busy = busy_o0;
            end
        endcase
    end

    bit pattern[$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int beats_of(input logic [1:0] s);
        case (s)
            2'd1:    return 2;
            2'd2:    return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: a line is BEATS consecutive 64-bit slices, beat k at bits 64k+63:64k;
    // address aligned down to the line size; latency = BEATS + 2 + stall cycles.
    // Called at a negedge in an IDLE cycle; returns at the negedge of the IDLE cycle
    // after DONE with the request already dropped.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [511:0] line, input int stall_pct, input bit fixed_data);
        int           nb;
        int           cyc;
        int           got;
        int           stalls;
        bit           done;
        bit           r;
        logic [511:0] exp_line;
        logic [511:0] shifted;
        logic [31:0]  exp_addr;
        nb       = beats_of(sel);
        exp_line = '0;
        exp_addr = addr & ~(32'(nb * 8) - 32'd1);
        tb_addr  = addr;
        tb_line  = line;
        req_rd   = rd;
        req_wr   = wr;
        resp_in  = 1'b0;
        cyc      = 1;
        got      = 0;
        stalls   = 0;
        done     = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (obs_resp) begin
                done = 1'b1;
            end else begin
                if (cyc == 2) begin
                    tb_addr = $urandom;
                    tb_line = rand512();
                end
                check("read_o_active", obs_read, rd);
                check("write_o_active", obs_write, wr && !rd);
                r = (pattern.size() > 0) ? pattern.pop_front() : ($urandom_range(99) >= stall_pct);
                if (got >= nb) r = 1'b0;
                shifted = line >> (64 * got);
                if (rd) check("burst_o_idle_zero", obs_burst, 64'd0);
                else    check("burst_o_beat", obs_burst, shifted[63:0]);
                burst_in = fixed_data ? {8{8'(8'h11 * (got + 1))}} : {$urandom, $urandom};
                resp_in  = r;
                if (r && rd) exp_line = exp_line | ({448'b0, burst_in} << (64 * got));
                if (r) got++;
                else   stalls++;
            end
        end
        check("resp_seen", done, 1'b1);
        check("latency", cyc, nb + 2 + stalls);
        check("address_o", obs_addr, exp_addr);
        check("read_o_done", obs_read, 1'b0);
        check("write_o_done", obs_write, 1'b0);
        check("busy_o_done", obs_busy, 1'b1);
        if (rd) check("line_o", obs_line, exp_line);
        resp_in  = 1'($urandom);
        burst_in = {$urandom, $urandom};
        @(negedge clk);
        check("resp_o_single", obs_resp, 1'b0);
        check("busy_o_idle", obs_busy, 1'b0);
        check("burst_o_after", obs_burst, 64'd0);
        if (rd) check("line_o_hold", obs_line, exp_line);
        req_rd  = 1'b0;
        req_wr  = 1'b0;
        resp_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_line"}, obs_line, '0);
        check({tag, "_burst"}, obs_burst, '0);
        check({tag, "_addr"}, obs_addr, '0);
        check({tag, "_rw"}, {obs_read, obs_write, obs_resp, obs_busy}, 4'd0);
    endtask

    logic [511:0] wline;
    int           no_retrig;

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // directed read with known beats
        sel = 2'd0;
        run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 0, 1'b1);
        check("read_line_const", obs_line,
              {256'b0, {4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});
        check("read_addr_const", obs_addr, 32'h0000_1220);
        @(negedge clk);
        check("no_retrigger", obs_busy, 1'b0);

        // directed write
        wline = {256'b0, {4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
        run_txn(1'b0, 1'b1, 32'hCAFE_0047, wline, 0, 1'b0);

        // fixed stall pattern
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_txn(1'b1, 1'b0, $urandom, '0, 0, 1'b0);

        // read and write together: read wins
        run_txn(1'b1, 1'b1, $urandom, rand512(), 30, 1'b0);

        // reset in the middle of a read after two beats
        @(negedge clk);
        tb_addr = 32'h0000_8040;
        req_rd  = 1'b1;
        @(negedge clk);
        resp_in  = 1'b1;
        burst_in = {$urandom, $urandom};
        @(negedge clk);
        burst_in = {$urandom, $urandom};
        @(negedge clk);
        resp_in = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        req_rd = 1'b0;
        @(posedge clk);
        #1 check("reset_no_resp", obs_resp, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", obs_resp, 1'b0);
        run_txn(1'b1, 1'b0, $urandom, '0, 25, 1'b0);

        // randomized traffic, back-to-back where requests follow immediately
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b1 & $urandom_range(1), 1'b1 & $urandom_range(1) | 1'b1, $urandom,
                    rand512(), $urandom_range(60), 1'b0);
        end

        // other line widths
        for (int s = 1; s < 3; s++) begin
            @(negedge clk);
            sel = 2'(s);
            run_txn(1'b0, 1'b1, $urandom, rand512(), 0, 1'b0);
            run_txn(1'b1, 1'b0, $urandom, '0, 0, 1'b0);
            run_txn(1'b1, 1'b0, $urandom, '0, 40, 1'b0);
            run_txn(1'b0, 1'b1, $urandom, rand512(), 40, 1'b0);
        end

        // idle stays idle when resp_i toggles with no request
        no_retrig = 0;
        for (int i = 0; i < 4; i++) begin
            resp_in = 1'b1;
            @(negedge clk);
            if (obs_busy) no_retrig++;
        end
        resp_in = 1'b0;
        check("idle_ignores_resp", no_retrig, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cacheline_burst_adaptor.md
# cacheline_burst_adaptor

Parametrised bridge between the last-level cache and the burst memory port. It converts one full-line read or write request into BEATS = LINE_WIDTH/BURST_WIDTH memory beats. It latches the request, aligns the address to a line boundary, and tolerates stall cycles between beats. It returns a single-cycle completion pulse to the cache.

## Interface
Parameters:
- LINE_WIDTH, 256: cache line width in bits; must be a multiple of BURST_WIDTH.
- BURST_WIDTH, 64: memory beat width in bits.
- ADDR_WIDTH, 32: byte address width.
- Derived BEATS = LINE_WIDTH/BURST_WIDTH; must be a power of two, at least 2.
- Derived OFFSET = $clog2(LINE_WIDTH/8).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- line_i  in  LINE_WIDTH  write data from the LLC.
- line_o  out  LINE_WIDTH  read data to the LLC.
- address_i  in  ADDR_WIDTH  request byte address.
- read_i  in  1  LLC read request, held until resp_o.
- write_i  in  1  LLC write request, held until resp_o.
- resp_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in any state other than IDLE.
- burst_i  in  BURST_WIDTH  read beat from memory.
- burst_o  out  BURST_WIDTH  write beat to memory.
- address_o  out  ADDR_WIDTH  line-aligned memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat acknowledge, one per beat.

## Operation
- States are IDLE, READ, WRITE and DONE.
- IDLE, read_i=1: latch address_o = {address_i[ADDR_WIDTH-1:OFFSET], OFFSET zeros}, clear the beat counter, go to READ.
- IDLE, write_i=0 or 1 with read_i=1: read wins; write_i is ignored.
- IDLE, write_i=1 and read_i=0: latch address_o as above and line_i into the write buffer, then go to WRITE.
- READ: read_o=1. On each resp_i, store burst_i into line slice [counter] (beat 0 occupies bits BURST_WIDTH-1:0) and increment the counter.
- READ exit: resp_i with counter==BEATS-1 goes to DONE.
- WRITE: write_o=1. burst_o is the write-buffer slice [counter]. On each resp_i, increment the counter.
- WRITE exit: resp_i with counter==BEATS-1 goes to DONE.
- DONE: resp_o=1 for exactly one cycle, then go to IDLE.
- resp_i low during READ or WRITE is a stall: the counter and state are held.
- resp_i in IDLE or DONE is ignored.
- line_o is driven from the read buffer. It holds its value until the next read beat overwrites it, so it is valid in DONE and afterwards.
- burst_o is 0 outside WRITE.
- Changes on line_i or address_i after they are latched have no effect on the transfer in progress.

## Timing
- Reset value of every output: line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0, busy_o=0. Counter and state also reset (state to IDLE).
- read_o, write_o, resp_o and address_o are registered outputs.
- read_o/write_o rise in the cycle after the request is sampled in IDLE.
- read_o/write_o fall in the cycle after the final beat's resp_i, which is the DONE cycle.
- Latency with no stalls is BEATS+2 cycles from the request-sampling edge to resp_o high. For BEATS=4, resp_o is high in cycle 6.
- Each stall cycle adds one cycle of latency.
- The LLC drops its request in the cycle after it sees resp_o. IDLE therefore never re-triggers on a request that has already completed.
- Back-to-back: a new request sampled in the IDLE cycle after DONE starts normally.
- Reset asserted mid-burst: all outputs clear immediately (asynchronously) and the partial line is discarded. No resp_o is produced for the aborted request.
- Counter width is $clog2(BEATS). It wraps to 0 on the final beat.

## Structure
- Package cacheline_adaptor_pkg holds the state enum type (IDLE/READ/WRITE/DONE) and the default width constants.
- Single module. Beat indexing uses indexed part-selects [counter*BURST_WIDTH +: BURST_WIDTH]; no sub-module.

## Test plan
- Read, BEATS=4, address_i=0x0000_1234: address_o=0x0000_1220. burst_i=0x11..,0x22..,0x33..,0x44.. with no stalls gives line_o={0x44..,0x33..,0x22..,0x11..}; resp_o is a single cycle, 6 cycles after the request.
- Write, line_i=0xDDDD..CCCC..BBBB..AAAA: burst_o presents 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. on successive resp_i; write_o falls in the DONE cycle.
- Stalls: resp_i pattern 1,0,0,1,1,0,1: beats are captured in order, no duplicated or skipped beat, and resp_o comes 3 cycles later than the no-stall case.
- Simultaneous read_i=write_i=1: the read path runs and write_o stays 0 throughout.
- Reset asserted after beat 2 of a read: outputs are 0 immediately, no resp_o; a following read completes correctly.
- Parameter sweep LINE_WIDTH=512 with BURST_WIDTH=64 (BEATS=8) and LINE_WIDTH=128 with BURST_WIDTH=64 (BEATS=2): round-trip data and latency equal BEATS+2 cycles.
